sync_fifo_stream: RTL



---
 rtl/sync_fifo_stream.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/sync_fifo_stream.sv
// -----------------------------------------------------------------------------
// sync_fifo_stream
//
// Single-clock stream FIFO with valid/ready handshakes on both sides and
// first-word-fall-through output. It has an optional registered output stage,
// programmable almost-full/almost-empty thresholds, a synchronous flush and a
// level counter that covers every word accepted and not yet popped. When the
// output stage is present, that count includes the word held in the stage.
//
// Parameters
//   DATA_WIDTH  word width in bits
//   DATA_DEPTH  memory entries (power of two, >= 2)
//   OUTPUT_REG  0: m_data read combinationally from memory
//               1: m_data driven from an output register
//   AF_TH       almost_full  when level >= AF_TH
//   AE_TH       almost_empty when level <= AE_TH
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   flush                 synchronous clear; beats push and pop
//   s_data/s_valid/s_ready  producer side
//   m_data/m_valid/m_ready  consumer side
//   level                 occupancy, 0..CAP (CAP = DATA_DEPTH + OUTPUT_REG)
//   full/empty/almost_full/almost_empty  status, decoded from level only
// -----------------------------------------------------------------------------
module sync_fifo_stream #(
    parameter int unsigned  DATA_WIDTH = 16,
    parameter int unsigned  DATA_DEPTH = 1024,
    parameter int unsigned  OUTPUT_REG = 0,
    parameter int unsigned  AF_TH      = DATA_DEPTH - 2,
    parameter int unsigned  AE_TH      = 1,
    localparam int unsigned CAP        = DATA_DEPTH + OUTPUT_REG,
    localparam int unsigned LW         = $clog2(CAP + 1),
    localparam int unsigned AW         = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LW-1:0]         level,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty
);

    localparam logic [LW-1:0] CAP_L = LW'(CAP);
    localparam logic [LW-1:0] AF_L  = LW'(AF_TH);
    localparam logic [LW-1:0] AE_L  = LW'(AE_TH);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic [LW-1:0] level_q,   level_d;

    logic push;     // accepted write this cycle
    logic pop;      // consumer takes the head word this cycle
    logic rd_adv;   // a word leaves memory this cycle

    // Status comes from the registered level alone, so s_ready never depends
    // combinationally on m_ready or s_valid.
    assign level        = level_q;
    assign s_ready      = (level_q < CAP_L);
    assign full         = (level_q == CAP_L);
    assign empty        = (level_q == '0);
    assign almost_full  = (level_q >= AF_L);
    assign almost_empty = (level_q <= AE_L);

    // A flush cycle discards any handshake, so neither counts.
    assign push = s_valid && s_ready && !flush;
    assign pop  = m_valid && m_ready && !flush;

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        level_d   = level_q;
        if (flush) begin
            wr_addr_d = '0;
            rd_addr_d = '0;
            level_d   = '0;
        end else begin
            if (push)   wr_addr_d = wr_addr_q + AW'(1);
            if (rd_adv) rd_addr_d = rd_addr_q + AW'(1);
            // Push and pop together leave the level unchanged at any fill.
            unique case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its _d input regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr_q <= '0;
            rd_addr_q <= '0;
            level_q   <= '0;
        end else begin
            wr_addr_q <= wr_addr_d;
            rd_addr_q <= rd_addr_d;
            level_q   <= level_d;
        end
    end

    // NOTE: the storage array has no reset; its contents are only observed
    // through the pointers and level, which are reset, so it can map to RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_addr_q] <= s_data;
        end
    end

    generate
        if (OUTPUT_REG != 0) begin : g_out_reg
            logic                  out_vld_q,  out_vld_d;
            logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
            logic                  mem_nonempty;
            logic                  load;

            // Words still in memory = level minus the one held in the stage.
            assign mem_nonempty = (level_q != LW'(out_vld_q));
            // Refill on the same edge as a pop, so back-to-back pops have no
            // bubble. A word pushed into an empty memory is not yet readable,
            // which gives the two-cycle write-to-valid latency.
            assign load = !flush && mem_nonempty && (!out_vld_q || pop);

            always_comb begin
                out_vld_d  = out_vld_q;
                out_data_d = out_data_q;
                if (flush) begin
                    out_vld_d = 1'b0;
                end else if (load) begin
                    out_vld_d  = 1'b1;
                    out_data_d = mem[rd_addr_q];
                end else if (pop) begin
                    out_vld_d = 1'b0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_vld_q  <= 1'b0;
                    out_data_q <= '0;
                end else begin
                    out_vld_q  <= out_vld_d;
                    out_data_q <= out_data_d;
                end
            end

            assign rd_adv  = load;
            assign m_valid = out_vld_q;
            assign m_data  = out_data_q;
        end else begin : g_out_comb
            assign rd_adv  = pop;
            assign m_valid = (level_q != '0);
            assign m_data  = mem[rd_addr_q];
        end
    endgenerate

endmodule
